// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding memory request, IF/ID write control,
// hold of a returned word across decode stalls, and branch redirect with stale-response drain.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Stall,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    output logic        MemReq,
    output logic [31:0] MemAddr,
    input  logic        MemReady,
    input  logic [31:0] MemData,
    output logic [31:0] PCOut,
    output logic [31:0] PCAddedOut,
    output logic [31:0] InstructionOut,
    output logic        IFIDWrite
);

    typedef enum logic [1:0] {FETCH, WAIT, HOLD, DRAIN} state_t;

    state_t      state, state_next;
    logic [31:0] pc, pc_next;
    logic [31:0] hold_word, hold_next;
    logic [31:0] pc_plus4;

    assign pc_plus4 = pc + 32'd4;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= FETCH;
            pc        <= RESET_PC;
            hold_word <= '0;
        end else begin
            state     <= state_next;
            pc        <= pc_next;
            hold_word <= hold_next;
        end
    end

    always_comb begin
        state_next     = state;
        pc_next        = pc;
        hold_next      = hold_word;
        MemReq         = 1'b0;
        MemAddr        = pc;
        PCOut          = '0;
        PCAddedOut     = '0;
        InstructionOut = NOP_WORD;
        IFIDWrite      = !Stall;

        if (Reset) begin
            IFIDWrite      = 1'b0;
            InstructionOut = '0;
        end else if (BranchTaken) begin
            // Flush: write a bubble; a response still in flight must be drained first
            IFIDWrite = 1'b1;
            pc_next   = BranchTarget;
            if ((state == WAIT || state == DRAIN) && !MemReady)
                state_next = DRAIN;
            else
                state_next = FETCH;
        end else begin
            case (state)
                FETCH: begin
                    MemReq     = 1'b1;
                    state_next = WAIT;
                end
                WAIT: begin
                    if (MemReady) begin
                        if (!Stall) begin
                            InstructionOut = MemData;
                            PCOut          = pc;
                            PCAddedOut     = pc_plus4;
                            IFIDWrite      = 1'b1;
                            pc_next        = pc_plus4;
                            state_next     = FETCH;
                        end else begin
                            hold_next  = MemData;
                            state_next = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (!Stall) begin
                        InstructionOut = hold_word;
                        PCOut          = pc;
                        PCAddedOut     = pc_plus4;
                        IFIDWrite      = 1'b1;
                        pc_next        = pc_plus4;
                        state_next     = FETCH;
                    end
                end
                DRAIN: begin
                    if (MemReady)
                        state_next = FETCH;
                end
                default: state_next = FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios with literal expectations, then randomized
// stall/branch/reset traffic against a transaction-level model and a variable-latency memory.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1, Stall = 1'b0, BranchTaken = 1'b0, MemReady = 1'b0;
    logic [31:0] BranchTarget = '0, MemData = '0;
    logic        MemReq, IFIDWrite;
    logic [31:0] MemAddr, PCOut, PCAddedOut, InstructionOut;

    fetch_unit #(.RESET_PC(RESET_PC), .NOP_WORD(NOP)) dut (
        .Clk(Clk), .Reset(Reset), .Stall(Stall), .BranchTaken(BranchTaken),
        .BranchTarget(BranchTarget), .MemReq(MemReq), .MemAddr(MemAddr),
        .MemReady(MemReady), .MemData(MemData), .PCOut(PCOut),
        .PCAddedOut(PCAddedOut), .InstructionOut(InstructionOut), .IFIDWrite(IFIDWrite)
    );

    always #5 Clk = ~Clk;

    int unsigned vectors = 0, miscompares = 0;

    // model of the fetch pipeline in transaction terms
    logic [31:0] m_pc = RESET_PC;
    bit          m_need = 1'b1, m_out = 1'b0, m_stale = 1'b0, m_held_v = 1'b0;
    logic [31:0] m_held_w = '0;

    // memory environment
    int unsigned mem_cnt = 0, lat_fixed = 0;
    logic [31:0] mem_a = '0;
    bit          ovr_en = 1'b0;
    logic [31:0] ovr_word = '0;

    logic        o_req, o_wr;
    logic [31:0] o_addr, o_pc, o_pca, o_ins;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic rst, input logic st, input logic bt, input logic [31:0] tgt);
        logic        rdy, e_req, e_wr, issued;
        logic [31:0] data, e_pc, e_pca, e_ins;
        @(negedge Clk);
        rdy  = (mem_cnt == 1);
        data = rdy ? (ovr_en ? ovr_word : mem_word(mem_a)) : $urandom;
        Reset = rst; Stall = st; BranchTaken = bt; BranchTarget = tgt;
        MemReady = rdy; MemData = data;
        #1;
        e_req = 1'b0; e_pc = '0; e_pca = '0; e_ins = NOP; e_wr = !st; issued = 1'b0;
        if (rst) begin
            e_wr = 1'b0; e_ins = '0;
        end else if (bt) begin
            e_wr = 1'b1;
        end else if (m_need) begin
            e_req = 1'b1;
        end else if (m_out) begin
            if (rdy && !m_stale && !st) begin
                e_ins = data; e_pc = m_pc; e_pca = m_pc + 32'd4; e_wr = 1'b1;
            end
        end else if (m_held_v && !st) begin
            e_ins = m_held_w; e_pc = m_pc; e_pca = m_pc + 32'd4; e_wr = 1'b1;
        end

        o_req = MemReq; o_addr = MemAddr; o_pc = PCOut; o_pca = PCAddedOut;
        o_ins = InstructionOut; o_wr = IFIDWrite;
        vectors++;
        if (o_req !== e_req || (e_req && o_addr !== m_pc) || o_pc !== e_pc ||
            o_pca !== e_pca || o_ins !== e_ins || o_wr !== e_wr) begin
            miscompares++;
            $display("FAIL cycle t=%0t: req/addr/pc/pca/ins/wr got %b/%08h/%08h/%08h/%08h/%b expected %b/%08h/%08h/%08h/%08h/%b",
                     $time, o_req, o_addr, o_pc, o_pca, o_ins, o_wr,
                     e_req, m_pc, e_pc, e_pca, e_ins, e_wr);
        end

        if (rst) begin
            m_pc = RESET_PC; m_need = 1; m_out = 0; m_stale = 0; m_held_v = 0; mem_cnt = 0;
        end else begin
            if (bt) begin
                if (m_out && !rdy) begin
                    m_stale = 1; m_need = 0;
                end else begin
                    m_out = 0; m_stale = 0; m_held_v = 0; m_need = 1;
                end
                m_pc = tgt;
            end else if (m_need) begin
                m_need = 0; m_out = 1; issued = 1; mem_a = m_pc;
            end else if (m_out && rdy) begin
                m_out = 0;
                if (m_stale) begin
                    m_stale = 0; m_need = 1;
                end else if (!st) begin
                    m_pc = m_pc + 32'd4; m_need = 1;
                end else begin
                    m_held_v = 1; m_held_w = data;
                end
            end else if (m_held_v && !st) begin
                m_held_v = 0; m_pc = m_pc + 32'd4; m_need = 1;
            end
            if (rdy) mem_cnt = 0;
            else if (mem_cnt > 1) mem_cnt--;
            if (issued) mem_cnt = (lat_fixed != 0) ? lat_fixed : $urandom_range(1, 3);
        end
    endtask

    initial begin
        lat_fixed = 1;
        step(1, 0, 0, 0);
        check("rst_req", {31'd0, o_req}, 0);
        check("rst_wr", {31'd0, o_wr}, 0);
        check("rst_ins", o_ins, 0);
        step(1, 1, 1, 32'h40);
        check("rst_override_wr", {31'd0, o_wr}, 0);

        // back-to-back fetches, latency 1
        step(0, 0, 0, 0); check("f0_addr", o_addr, 32'h0); check("f0_req", {31'd0, o_req}, 1);
        step(0, 0, 0, 0); check("d0_pc", o_pc, 0); check("d0_pca", o_pca, 4);
        step(0, 0, 0, 0); check("f1_addr", o_addr, 32'h4);
        step(0, 0, 0, 0); check("d1_pca", o_pca, 8);
        step(0, 0, 0, 0); check("f2_addr", o_addr, 32'h8);
        step(0, 0, 0, 0); check("d2_pc", o_pc, 8); check("d2_pca", o_pca, 12);

        // stall across response
        step(0, 0, 0, 0); check("f3_addr", o_addr, 32'hC);
        ovr_en = 1; ovr_word = 32'h2008_0005;
        step(0, 1, 0, 0); check("stall0_wr", {31'd0, o_wr}, 0);
        ovr_en = 0;
        step(0, 1, 0, 0); check("stall1_wr", {31'd0, o_wr}, 0);
        step(0, 1, 0, 0); check("stall2_wr", {31'd0, o_wr}, 0);
        step(0, 0, 0, 0); check("held_ins", o_ins, 32'h2008_0005); check("held_pc", o_pc, 32'hC);
        lat_fixed = 3;
        step(0, 0, 0, 0); check("f4_addr", o_addr, 32'h10);

        // branch while waiting: drain stale response
        step(0, 0, 1, 32'h100); check("br_wr", {31'd0, o_wr}, 1); check("br_ins", o_ins, NOP);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0); check("drain_ins", o_ins, NOP); check("drain_pc", o_pc, 0);
        lat_fixed = 1;
        step(0, 0, 0, 0); check("br_addr", o_addr, 32'h100);

        // branch dominates stall and ready
        step(0, 1, 1, 32'h200); check("bsr_wr", {31'd0, o_wr}, 1); check("bsr_ins", o_ins, NOP);
        step(0, 0, 0, 0); check("bsr_addr", o_addr, 32'h200);

        // PC wrap
        step(0, 0, 1, 32'hFFFF_FFFC);
        step(0, 0, 0, 0); check("wrap_addr", o_addr, 32'hFFFF_FFFC);
        step(0, 0, 0, 0); check("wrap_pca", o_pca, 0); check("wrap_pc", o_pc, 32'hFFFF_FFFC);
        step(0, 0, 0, 0); check("wrap_next", o_addr, 0);

        // reset while holding
        step(0, 1, 0, 0);
        step(1, 1, 0, 0); check("rh_ins", o_ins, 0); check("rh_wr", {31'd0, o_wr}, 0);
        step(0, 0, 0, 0); check("rh_addr", o_addr, RESET_PC); check("rh_req", {31'd0, o_req}, 1);
        step(0, 0, 0, 0); check("rh_pc", o_pc, RESET_PC);

        lat_fixed = 0;
        for (int i = 0; i < 4000; i++) begin
            automatic logic r  = ($urandom_range(0, 99) < 1);
            automatic logic s  = ($urandom_range(0, 99) < 30);
            automatic logic b  = ($urandom_range(0, 99) < 5);
            automatic logic [31:0] t = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            step(r, s, b, t);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
